// File: rtl/ff_style_pkg.sv
// Shared constants and labels for the ff_style_bank register set.
package ff_style_pkg;

  // All-zero reset fill; users slice the low WIDTH bits (widths up to 64).
  localparam logic [63:0] RESET_VAL = '0;

  // Names the three register styles; used for labelling only.
  typedef enum logic [1:0] {
    FF_F1 = 2'd0,
    FF_F2 = 2'd1,
    FF_F3 = 2'd2
  } ff_style_e;

endpackage

// File: rtl/ff_stage.sv
// One rising-edge register stage with synchronous active-high clear, no enable.
module ff_stage
  import ff_style_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on every rising edge; reset wins over data.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL[WIDTH-1:0];
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ff_style_bank.sv
// Golden flop set: single register (F1), two-stage pipeline (F2) and
// registered complement (F3), all sharing one clock and synchronous reset.
// Every output comes straight from a flop, so nothing in d reaches an output
// without a clock edge in between.
module ff_style_bank
  import ff_style_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q1,
  output logic [SIZE-1:0] q2,
  output logic [SIZE-1:0] q3
);

  logic [SIZE-1:0] f2_stage;
  logic [SIZE-1:0] d_inv;

  // Inverting before the flop keeps the reset value of q3 at zero.
  assign d_inv = ~d;

  ff_stage #(.WIDTH(SIZE)) u_f1 (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q1)
  );

  ff_stage #(.WIDTH(SIZE)) u_f2_a (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (f2_stage)
  );

  ff_stage #(.WIDTH(SIZE)) u_f2_b (
    .clk (clk),
    .rst (rst),
    .d   (f2_stage),
    .q   (q2)
  );

  ff_stage #(.WIDTH(SIZE)) u_f3 (
    .clk (clk),
    .rst (rst),
    .d   (d_inv),
    .q   (q3)
  );

endmodule

// File: tb/tb_ff_style_bank.sv
// Bench for ff_style_bank: directed SIZE=4 sequence, then a random 4-state
// comparison of SIZE=4 and SIZE=1 instances against a sample-history model.
module tb_ff_style_bank;
  import ff_style_pkg::*;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset (directed instance) ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d   = 4'h0;
  logic [3:0] q1, q2, q3;

  always #5 clk = ~clk;

  ff_style_bank #(.SIZE(4)) u_dut (
    .clk (clk), .rst (rst), .d (d), .q1 (q1), .q2 (q2), .q3 (q3)
  );

  // ---------------- random instances (own clock) ----------------
  logic       clk_r = 1'b0;
  logic       rst_r = 1'b1;
  logic [3:0] d_r   = 4'h0;
  logic [3:0] r4_q1, r4_q2, r4_q3;
  logic       r1_q1, r1_q2, r1_q3;

  ff_style_bank #(.SIZE(4)) u_r4 (
    .clk (clk_r), .rst (rst_r), .d (d_r), .q1 (r4_q1), .q2 (r4_q2), .q3 (r4_q3)
  );

  ff_style_bank #(.SIZE(1)) u_r1 (
    .clk (clk_r), .rst (rst_r), .d (d_r[0]), .q1 (r1_q1), .q2 (r1_q2), .q3 (r1_q3)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rand_bit4s();
    logic b;
    case ($urandom_range(0, 3))
      0:       b = 1'b0;
      1:       b = 1'b1;
      2:       b = 1'bx;
      default: b = 1'bz;
    endcase
    return b;
  endfunction

  function automatic logic [3:0] rand_vec4s();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = rand_bit4s();
    return v;
  endfunction

  // ---------------- reference model ----------------
  // The model keeps the last two sampled inputs since reset. q1 is the newest
  // sample, q2 the one before it, q3 the complement of the newest sample,
  // except that directly after a reset edge every output is zero.
  logic [3:0] hist[$];
  bit         m_just_reset = 1'b0;

  task automatic model_edge(input logic r, input logic [3:0] din);
    if (r) begin
      hist = {4'h0, 4'h0};
      m_just_reset = 1'b1;
    end else begin
      hist.push_back(din);
      if (hist.size() > 2) void'(hist.pop_front());
      m_just_reset = 1'b0;
    end
  endtask

  function automatic logic [3:0] model_out(input ff_style_e s);
    case (s)
      FF_F1:   return hist[1];
      FF_F2:   return hist[0];
      default: return m_just_reset ? 4'h0 : ~hist[1];
    endcase
  endfunction

  function automatic logic [3:0] r4_out(input ff_style_e s);
    case (s)
      FF_F1:   return r4_q1;
      FF_F2:   return r4_q2;
      default: return r4_q3;
    endcase
  endfunction

  function automatic logic r1_out(input ff_style_e s);
    case (s)
      FF_F1:   return r1_q1;
      FF_F2:   return r1_q2;
      default: return r1_q3;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] dv;
    logic [3:0] exp_q1, exp_q3;
    bit         seen_reset;
    bit         new_clk;
    logic [3:0] exp_v;
    ff_style_e  sty;

    // Reset for two edges with d all ones.
    rst = 1'b1; d = 4'hF;
    #2;
    tick();
    check_eq("rst_q1", q1, 4'h0);
    check_eq("rst_q2", q2, 4'h0);
    check_eq("rst_q3", q3, 4'h0);
    tick();

    // F1 / F3 latency; q2 still shows the reset value.
    rst = 1'b0; d = 4'hA;
    tick();
    check_eq("f1_lat", q1, 4'hA);
    check_eq("f3_lat", q3, 4'h5);
    check_eq("f2_after_rst", q2, 4'h0);

    // F2 latency.
    d = 4'h3;
    tick();
    check_eq("f1_3", q1, 4'h3);
    check_eq("f2_prior", q2, 4'hA);
    d = 4'hC;
    tick();
    check_eq("f2_3", q2, 4'h3);
    check_eq("f3_c", q3, 4'h3);

    // Reset mid-stream with the F2 pipeline full (q2=3, stage=C).
    rst = 1'b1; d = 4'h6;
    tick();
    check_eq("mid_rst_q1", q1, 4'h0);
    check_eq("mid_rst_q2", q2, 4'h0);
    check_eq("mid_rst_q3", q3, 4'h0);
    rst = 1'b0; d = 4'h9;
    tick();
    check_eq("post_rst_q2_zero", q2, 4'h0);
    check_eq("post_rst_q1", q1, 4'h9);
    d = 4'h2;
    tick();
    check_eq("post_rst_q2_9", q2, 4'h9);

    // 4-state propagation.
    dv = 4'b01xz;
    d = dv;
    exp_q1 = dv;
    exp_q3 = ~dv;
    tick();
    check_eq("x_q1", q1, exp_q1);
    check_eq("x_q3", q3, exp_q3);
    d = 4'h0;
    tick();
    check_eq("x_q2", q2, exp_q1);

    // Outputs hold between edges.
    d = 4'hF;
    #3;
    check_eq("hold_q1", q1, 4'h0);
    check_eq("hold_q2", q2, exp_q1);

    // Random comparison: data/reset change at tick 0, clock at tick 1,
    // outputs checked at tick 2 of every 3-tick step.
    seen_reset = 1'b0;
    for (int i = 0; i < 33333; i++) begin
      d_r   = rand_vec4s();
      rst_r = (i < 4) || ($urandom_range(0, 49) == 0);
      #1;
      new_clk = 1'($urandom_range(0, 1));
      if (!clk_r && new_clk) begin
        model_edge(rst_r, d_r);
        if (rst_r) seen_reset = 1'b1;
      end
      clk_r = new_clk;
      #1;
      if (seen_reset) begin
        for (int s = 0; s < 3; s++) begin
          sty   = ff_style_e'(s);
          exp_v = model_out(sty);
          check_eq({"rand4_", sty.name()}, r4_out(sty), exp_v);
          check_eq({"rand1_", sty.name()}, {3'b000, r1_out(sty)}, {3'b000, exp_v[0]});
        end
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
